// File: rtl/hop_sched_pkg.sv
// hop_sched_pkg: shared state/mode encodings and the index-to-phase mapping
package hop_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GAP  = 2'b01,
        ST_TX   = 2'b10
    } state_e;

    typedef enum logic {
        MODE_LINEAR = 1'b0,
        MODE_STRIDE = 1'b1
    } mode_e;

    // Full-width result; callers truncate to their phase width with a size cast.
    function automatic logic [63:0] phase_from_idx(input logic [63:0] start,
                                                    input logic [63:0] dph,
                                                    input logic [63:0] idx);
        return start + idx * dph;
    endfunction

endpackage

// File: rtl/hop_idx_gen.sv
// hop_idx_gen: registered hop index with linear/stride wrap and its phase increment
module hop_idx_gen
    import hop_sched_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int NHOP_WIDTH = 8,
    parameter int NUM_HOPS = 64,
    parameter int HOP_STRIDE = 37,
    parameter logic [PHASE_WIDTH-1:0] HOP_START_PH_INC = 24'hC00000,
    parameter int HOP_DPH_INC = 131072
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   step,
    input  mode_e                  mode,
    output logic [NHOP_WIDTH-1:0]  idx,
    output logic [PHASE_WIDTH-1:0] phase_inc
);
    localparam logic [NHOP_WIDTH-1:0] MASK = NHOP_WIDTH'(NUM_HOPS - 1);
    localparam logic [NHOP_WIDTH-1:0] STRIDE = NHOP_WIDTH'(HOP_STRIDE);

    logic [NHOP_WIDTH-1:0]  idx_q, idx_d;
    logic [PHASE_WIDTH-1:0] ph_q, ph_d;

    always_comb begin
        idx_d = clear ? '0
              : step ? (idx_q + (mode == MODE_STRIDE ? STRIDE : NHOP_WIDTH'(1))) & MASK
              : idx_q;
        ph_d = PHASE_WIDTH'(phase_from_idx(64'(HOP_START_PH_INC), 64'(HOP_DPH_INC), 64'(idx_d)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            ph_q <= HOP_START_PH_INC;
        end else begin
            idx_q <= idx_d;
            ph_q <= ph_d;
        end
    end

    assign idx = idx_q;
    assign phase_inc = ph_q;
endmodule

// File: rtl/hop_sched_ctrl.sv
// hop_sched_ctrl: walks the hop schedule, gating the datapath with srst for a sync gap per hop
module hop_sched_ctrl
    import hop_sched_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int NHOP_WIDTH = 8,
    parameter int NUM_HOPS = 64,
    parameter int HOP_STRIDE = 37,
    parameter int GAP_WIDTH = 16,
    parameter int SYNC_GAP = 16384,
    parameter logic [PHASE_WIDTH-1:0] HOP_START_PH_INC = 24'hC00000,
    parameter int HOP_DPH_INC = 131072,
    parameter int NREP_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mode,
    input  logic [NREP_WIDTH-1:0]  nrep,
    input  logic                   hop_ready,
    output logic                   srst,
    output logic [PHASE_WIDTH-1:0] hop_phase_inc,
    output logic [NHOP_WIDTH-1:0]  hop_idx,
    output logic [NHOP_WIDTH-1:0]  hop_cnt,
    output logic                   busy,
    output logic                   sweep_done,
    output logic [1:0]             sched_state
);
    localparam logic [GAP_WIDTH-1:0] GAP_RELOAD = GAP_WIDTH'(SYNC_GAP - 1);
    localparam logic [NHOP_WIDTH-1:0] LAST_CNT = NHOP_WIDTH'(NUM_HOPS - 1);

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [NREP_WIDTH-1:0]  rep_q, rep_d, nrep_q, nrep_d;
    logic [NHOP_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   srst_q, srst_d, busy_q, busy_d, done_q, done_d;
    logic                   clear, step, last, final_rep;

    assign last = cnt_q == LAST_CNT;
    assign final_rep = (nrep_q != '0) && (rep_q == nrep_q - NREP_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        mode_d = mode_q;
        gap_d = gap_q;
        rep_d = rep_q;
        nrep_d = nrep_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
        clear = 1'b0;
        step = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            gap_d = GAP_RELOAD;
            rep_d = '0;
            cnt_d = '0;
            clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    mode_d = mode_e'(mode);
                    nrep_d = nrep;
                    gap_d = GAP_RELOAD;
                    rep_d = '0;
                    cnt_d = '0;
                    clear = 1'b1;
                    state_d = ST_GAP;
                end
                ST_GAP: begin
                    gap_d = (gap_q != '0) ? gap_q - GAP_WIDTH'(1) : gap_q;
                    state_d = (gap_q == '0) ? ST_TX : ST_GAP;
                end
                ST_TX: if (hop_ready) begin
                    gap_d = GAP_RELOAD;
                    done_d = last;
                    if (!last) begin
                        cnt_d = cnt_q + NHOP_WIDTH'(1);
                        step = 1'b1;
                        state_d = ST_GAP;
                    end else if (final_rep) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Continuous mode keeps counting sweeps but must not wrap.
                        rep_d = (&rep_q) ? rep_q : rep_q + NREP_WIDTH'(1);
                        cnt_d = '0;
                        clear = 1'b1;
                        state_d = ST_GAP;
                    end
                end
                default: ;
            endcase
        end
        srst_d = state_d != ST_TX;
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q <= MODE_LINEAR;
            gap_q <= GAP_RELOAD;
            rep_q <= '0;
            nrep_q <= '0;
            cnt_q <= '0;
            srst_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q <= mode_d;
            gap_q <= gap_d;
            rep_q <= rep_d;
            nrep_q <= nrep_d;
            cnt_q <= cnt_d;
            srst_q <= srst_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    hop_idx_gen #(
        .PHASE_WIDTH(PHASE_WIDTH),
        .NHOP_WIDTH(NHOP_WIDTH),
        .NUM_HOPS(NUM_HOPS),
        .HOP_STRIDE(HOP_STRIDE),
        .HOP_START_PH_INC(HOP_START_PH_INC),
        .HOP_DPH_INC(HOP_DPH_INC)
    ) u_idx (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .step(step),
        .mode(mode_q),
        .idx(hop_idx),
        .phase_inc(hop_phase_inc)
    );

    assign srst = srst_q;
    assign busy = busy_q;
    assign sweep_done = done_q;
    assign hop_cnt = cnt_q;
    assign sched_state = state_q;
endmodule

// File: tb/tb_hop_sched_ctrl.sv
// tb_hop_sched_ctrl: directed vector table plus hand-written multi-cycle sequences
module tb_hop_sched_ctrl;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, mode = 1'b0, hop_ready = 1'b0;
    logic [7:0] nrep = 8'd0;
    logic srst, busy, sweep_done;
    logic [23:0] hop_phase_inc;
    logic [7:0] hop_idx, hop_cnt;
    logic [1:0] sched_state;
    int total = 0, bad = 0;

    hop_sched_ctrl #(
        .NUM_HOPS(4),
        .SYNC_GAP(4),
        .HOP_STRIDE(3),
        .HOP_START_PH_INC(24'h100000),
        .HOP_DPH_INC(32'h10000)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode), .nrep(nrep),
        .hop_ready(hop_ready), .srst(srst), .hop_phase_inc(hop_phase_inc), .hop_idx(hop_idx),
        .hop_cnt(hop_cnt), .busy(busy), .sweep_done(sweep_done), .sched_state(sched_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic st, ab, md;
        logic [7:0] nr;
        logic rd;
        logic e_srst, e_busy;
        logic [7:0] e_idx, e_cnt;
        logic e_done;
        logic [1:0] e_state;
        logic [23:0] e_ph;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic st, ab, md, input logic [7:0] nr, input logic rd,
                                input logic s, b, input logic [7:0] i, c, input logic d,
                                input logic [1:0] sta, input logic [23:0] ph);
        tbl.push_back('{st, ab, md, nr, rd, s, b, i, c, d, sta, ph});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic st, ab, md, input logic [7:0] nr, input logic rd);
        start = st; abort = ab; mode = md; nrep = nr; hop_ready = rd;
        @(posedge clk);
        #1;
        start = 0; abort = 0; hop_ready = 0;
    endtask

    // Entered just after the edge that put the DUT in GAP; returns after the hop_ready edge.
    task automatic hop(output int idx, output int gaps, output int dones, output logic [23:0] ph);
        gaps = 0;
        dones = 0;
        for (int k = 0; k < 20 && srst; k++) begin
            gaps++;
            tick(0, 0, 0, 0, 0);
            dones += int'(sweep_done);
        end
        idx = int'(hop_idx);
        ph = hop_phase_inc;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        dones += int'(sweep_done);
    endtask

    task automatic to_tx(output int n);
        n = 0;
        while (srst && n < 20) begin
            tick(0, 0, 0, 0, 0);
            n++;
        end
    endtask

    int idx, gaps, dones, sum, n;
    logic [23:0] ph;
    int seq_m1[8] = '{0, 3, 2, 1, 0, 3, 2, 1};

    initial begin
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 24'h100000);
        add(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2'd1, 24'h100000);
        for (int h = 0; h < 4; h++) begin
            for (int g = 0; g < 3; g++)
                add(0, 0, 0, 0, 0, 1, 1, 8'(h), 8'(h), 0, 2'd1, 24'h100000 + 24'(h) * 24'h10000);
            for (int t = 0; t < 2; t++)
                add(0, 0, 0, 0, 0, 0, 1, 8'(h), 8'(h), 0, 2'd2, 24'h100000 + 24'(h) * 24'h10000);
            if (h < 3)
                add(0, 0, 0, 0, 1, 1, 1, 8'(h + 1), 8'(h + 1), 0, 2'd1, 24'h100000 + 24'(h + 1) * 24'h10000);
            else
                add(0, 0, 0, 0, 1, 1, 0, 8'd3, 8'd3, 1, 2'd0, 24'h130000);
        end
        add(0, 0, 0, 0, 0, 1, 0, 8'd3, 8'd3, 0, 2'd0, 24'h130000);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_srst", 64'(srst), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ph", 64'(hop_phase_inc), 64'h100000);
        reset = 0;

        foreach (tbl[i]) begin
            tick(tbl[i].st, tbl[i].ab, tbl[i].md, tbl[i].nr, tbl[i].rd);
            chk($sformatf("vec%0d", i),
                64'({srst, busy, hop_idx, hop_cnt, sweep_done, sched_state, hop_phase_inc}),
                64'({tbl[i].e_srst, tbl[i].e_busy, tbl[i].e_idx, tbl[i].e_cnt, tbl[i].e_done,
                     tbl[i].e_state, tbl[i].e_ph}));
        end

        // Stride order, two sweeps
        tick(1, 0, 1, 8'd2, 0);
        sum = 0;
        for (int h = 0; h < 8; h++) begin
            if (h == 7) chk("m1_busy_before_last", 64'(busy), 64'd1);
            hop(idx, gaps, dones, ph);
            sum += dones;
            chk($sformatf("m1_idx%0d", h), 64'(idx), 64'(seq_m1[h]));
            chk($sformatf("m1_gap%0d", h), 64'(gaps), 64'd4);
            chk($sformatf("m1_ph%0d", h), 64'(ph), 64'h100000 + 64'(seq_m1[h]) * 64'h10000);
        end
        chk("m1_dones", 64'(sum), 64'd2);
        chk("m1_busy_end", 64'(busy), 64'd0);

        // Continuous mode, then abort during GAP
        tick(1, 0, 0, 8'd0, 0);
        sum = 0;
        for (int h = 0; h < 13; h++) begin
            hop(idx, gaps, dones, ph);
            sum += dones;
            chk($sformatf("cont_idx%0d", h), 64'(idx), 64'(h % 4));
        end
        chk("cont_dones", 64'(sum), 64'd3);
        chk("cont_busy", 64'(busy), 64'd1);
        chk("cont_in_gap", 64'(sched_state), 64'd1);
        tick(0, 1, 0, 0, 0);
        chk("abort_gap", 64'({sched_state, srst, busy, sweep_done, hop_idx, hop_cnt, hop_phase_inc}),
            64'({2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 24'h100000}));

        // Ignored start/hop_ready while busy, then abort racing hop_ready
        tick(1, 0, 0, 8'd1, 0);
        hop(idx, gaps, dones, ph);
        chk("ign_first_idx", 64'(idx), 64'd0);
        tick(1, 0, 1, 8'd2, 0);
        tick(0, 0, 0, 0, 1);
        chk("ign_state", 64'({sched_state, hop_idx, hop_cnt}), 64'({2'd1, 8'd1, 8'd1}));
        hop(idx, gaps, dones, ph);
        chk("ign_idx", 64'(idx), 64'd1);
        chk("ign_gaps", 64'(gaps), 64'd2);
        to_tx(n);
        chk("ign_reach_tx", 64'(srst), 64'd0);
        tick(0, 1, 0, 0, 1);
        chk("abort_rdy", 64'({sched_state, busy, sweep_done, hop_idx, hop_cnt}),
            64'({2'd0, 1'b0, 1'b0, 8'd0, 8'd0}));
        tick(1, 1, 0, 8'd1, 0);
        chk("start_abort_idle", 64'({sched_state, busy, srst}), 64'({2'd0, 1'b0, 1'b1}));

        // Asynchronous reset in the middle of TX
        tick(1, 0, 0, 8'd1, 0);
        hop(idx, gaps, dones, ph);
        to_tx(n);
        chk("pre_rst_srst", 64'(srst), 64'd0);
        #2 reset = 1;
        #1;
        chk("async_rst", 64'({srst, busy, sched_state, hop_idx, hop_cnt}),
            64'({1'b1, 1'b0, 2'd0, 8'd0, 8'd0}));
        #1 reset = 0;
        tick(1, 0, 1, 8'd1, 0);
        hop(idx, gaps, dones, ph);
        chk("restart_idx0", 64'(idx), 64'd0);
        hop(idx, gaps, dones, ph);
        chk("restart_idx1", 64'(idx), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
